mult_div_unit: RTL

- Execute-stage multiply/divide unit (MDU).
- Consumes the MDU enable and MDU opcode produced by the instruction decoder, together with forwarded rs/rt operands.
- Runs multi-cycle signed/unsigned mult/div and owns the architectural HI/LO registers.
- Provides Busy and HI/LO to the hazard unit and to the E-stage result mux (MFHI/MFLO path).

---
 rtl/mult_div_unit_pkg.sv | 29 ++
 rtl/mult_div_unit_if.sv | 20 ++
 rtl/mult_div_unit_arith.sv | 52 +++++
 rtl/mult_div_unit.sv | 88 ++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// MDU shared encodings: opcode enum shared with the decoder,
// FSM states and opcode classification helpers.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'b000,
    MDU_MULT  = 3'b001,
    MDU_MULTU = 3'b010,
    MDU_DIV   = 3'b011,
    MDU_DIVU  = 3'b100,
    MDU_MTHI  = 3'b101,
    MDU_MTLO  = 3'b110
  } mdu_op_e;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } mdu_state_e;

  function automatic logic is_start(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mul(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Decoder/E-stage command bundle into the MDU and HI/LO/Busy back out.
interface mdu_if;
  logic        MDUEN;
  logic [2:0]  MDUCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output MDUEN, MDUCtrl, A, B,
    input  Busy, HI, LO
  );

  modport slave (
    input  MDUEN, MDUCtrl, A, B,
    output Busy, HI, LO
  );
endinterface

// File: rtl/mult_div_unit_arith.sv
// Combinational mult/div datapath; result is {hi, lo}.
// Divide by zero is flagged so the caller can leave HI/LO untouched.
module mdu_arith
  import mult_div_unit_pkg::*;
(
  input  mdu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o,
  output logic        dz_o
);

  logic [63:0]        sa;
  logic [63:0]        sb;
  logic signed [31:0] sq;
  logic signed [31:0] sr;

  always_comb begin
    res_o = '0;
    dz_o  = 1'b0;
    sa    = {{32{a_i[31]}}, a_i};
    sb    = {{32{b_i[31]}}, b_i};
    sq    = '0;
    sr    = '0;
    case (op_i)
      MDU_MULT:  res_o = sa * sb;
      MDU_MULTU: res_o = {32'd0, a_i} * {32'd0, b_i};
      MDU_DIV: begin
        if (b_i == 32'd0) begin
          dz_o = 1'b1;
        end else if (a_i == 32'h8000_0000 &&
                     b_i == 32'hFFFF_FFFF) begin
          // Overflow case: quotient wraps, no remainder
          res_o = {32'd0, 32'h8000_0000};
        end else begin
          sq    = $signed(a_i) / $signed(b_i);
          sr    = $signed(a_i) % $signed(b_i);
          res_o = {sr, sq};
        end
      end
      MDU_DIVU: begin
        if (b_i == 32'd0) begin
          dz_o = 1'b1;
        end else begin
          res_o = {a_i % b_i, a_i / b_i};
        end
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage MDU: multi-cycle mult/div with a single
// down-counter, result latched at start and committed at the end.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset,
  mdu_if.slave   bus
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;

  mdu_state_e  state_q;
  logic        busy_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [63:0] pend_q;
  logic        pend_dz_q;

  mdu_op_e     op;
  logic [63:0] res_d;
  logic        dz_d;

  assign op = mdu_op_e'(bus.MDUCtrl);

  mdu_arith u_arith (
    .op_i  (op),
    .a_i   (bus.A),
    .b_i   (bus.B),
    .res_o (res_d),
    .dz_o  (dz_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.MDUEN) begin
            if (is_start(op)) begin
              pend_q    <= res_d;
              pend_dz_q <= dz_d;
              cnt_q     <= is_mul(op) ? CW'(MULT_CYCLES)
                                      : CW'(DIV_CYCLES);
              busy_q    <= 1'b1;
              state_q   <= S_RUN;
            end else if (op == MDU_MTHI) begin
              hi_q <= bus.A;
            end else if (op == MDU_MTLO) begin
              lo_q <= bus.A;
            end
          end
        end
        S_RUN: begin
          if (cnt_q == CW'(1)) begin
            if (!pend_dz_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
